bjack_hand_ctrl: RTL and testbench
==================================

# bjack_hand_ctrl

Parametrised blackjack hand controller. It requests cards, accumulates the hand total, and decides hit, hold or bust. It generalises the single-ace fixed-21 player controller: the target, stand threshold and widths are configurable, any number of aces can be softened, a card-count limit ("charlie") is supported, and a natural-blackjack flag is reported. It sits between the card dealer (CARD/NEW_C handshake) and the game-level scoring logic.

## Interface
- CARD_W, 4, width of CARD input
- TOTAL_W, 6, width of HAND; must hold STAND_AT-1 + 2^CARD_W-1 without wrap
- TARGET, 21, highest non-bust total
- STAND_AT, 17, hold when TARGET >= total >= STAND_AT
- ACE_VAL, 11, CARD code that is an ace (counted as ACE_VAL)
- ACE_DROP, 10, amount subtracted when softening one ace
- MAX_CARDS, 5, hold unconditionally once this many cards are taken without bust
- CNT_W, 3, width of CARDS and internal ace counter
- CLOCK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- CARD  in  CARD_W  card value, sampled when NEW_C accepted
- NEW_C  in  1  dealer strobe: card valid
- NEW_G  in  1  synchronous new-game request
- NEXT_C  out  1  card request (state HIT)
- HAND  out  TOTAL_W  current total
- CARDS  out  CNT_W  cards taken this hand
- SOFT  out  1  at least one ace still counted as ACE_VAL
- HOLD  out  1  state HOLD
- BUST  out  1  state BUST
- NATURAL  out  1  HOLD with CARDS==2 and HAND==TARGET

## Operation
- Registers: state, total (TOTAL_W), aces (CNT_W), count (CNT_W). HAND=total, CARDS=count, SOFT=(aces!=0).
- RESET=1: state IDLE, total=0, aces=0, count=0; all outputs 0.
- NEW_G=1 at a clock edge, any state: state BEGIN, total/aces/count cleared. NEW_G overrides NEW_C in the same cycle.
- States, all moves on the rising edge:
  - IDLE: stay until NEW_G.
  - BEGIN: go to HIT.
  - HIT: NEXT_C=1. If NEW_C=1: total += zero-extended CARD; if CARD==ACE_VAL, aces++ (saturate at 2^CNT_W-1); count++; go to GOT. Otherwise stay.
  - GOT: wait for NEW_C=0, then go to TEST. One card per strobe, regardless of how long NEW_C stays high.
  - TEST: if total>TARGET: go to SOFTEN if aces!=0, else BUST. Else if count==MAX_CARDS: HOLD. Else if total>=STAND_AT: HOLD. Else HIT.
  - SOFTEN: total -= ACE_DROP; aces--; go to TEST. Repeats per ace until total<=TARGET or aces==0.
  - HOLD, BUST: terminal; stay until NEW_G or RESET.
- Arithmetic is unsigned. Total never wraps under the TOTAL_W rule. A CARD of 0 or above ACE_VAL is added as-is (dealer responsibility).
- total==TARGET holds; it is never a bust.

## Timing
- All outputs are decoded from registers only (Moore); no combinational path from inputs to outputs.
- Card accept: the edge where HIT and NEW_C=1; HAND updates that edge and NEXT_C drops that edge.
- NEW_C falls → TEST on the next edge → HOLD/BUST/HIT/SOFTEN on the following edge. Each softening adds 2 cycles.
- NEW_G → BEGIN on the next edge → NEXT_C=1 one edge later.
- RESET asserted mid-hand clears everything immediately, without waiting for a clock. After RESET deasserts, the block stays in IDLE until NEW_G.

## Test plan
- RESET, NEW_G, cards 10 then 7 → HAND=17, CARDS=2, HOLD=1, NATURAL=0, NEXT_C=0.
- NEW_G, cards 11 then 10 → HAND=21, HOLD=1, NATURAL=1, SOFT=1.
- Cards 11, 11 → 22 soften to 12 (SOFT=1), HIT; card 10 → 22 soften to 12 (SOFT=0), HIT; card 10 → HAND=22, BUST=1. Covers multiple aces.
- Cards 10, 6, 10 → HAND=26, BUST=1. BUST held through 20 cycles of NEW_C toggling; NEW_G → HAND=0, NEXT_C=1 two edges later.
- MAX_CARDS=5, cards 2,2,2,2,2 → HAND=10, CARDS=5, HOLD=1. Also hold NEW_C high 4 cycles in HIT → only one card added.
- RESET pulse between clock edges while in GOT → all outputs 0 immediately; NEW_G together with NEW_C → card ignored, BEGIN.

Source files
------------

// File: rtl/bjack_hand_ctrl.sv
// Blackjack hand controller: requests cards, accumulates the total, softens aces, decides hold/bust.
// Latency: card accepted on the edge it is seen in HIT; verdict two edges after NEW_C falls (+2 per ace softened).
// Backpressure: one card per NEW_C strobe; a strobe held high is consumed once, and NEXT_C stays low until the hand is re-evaluated.
module bjack_hand_ctrl #(
  parameter int CARD_W    = 4,
  parameter int TOTAL_W   = 6,
  parameter int TARGET    = 21,
  parameter int STAND_AT  = 17,
  parameter int ACE_VAL   = 11,
  parameter int ACE_DROP  = 10,
  parameter int MAX_CARDS = 5,
  parameter int CNT_W     = 3
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [CARD_W-1:0]  CARD,
  input  logic               NEW_C,
  input  logic               NEW_G,
  output logic               NEXT_C,
  output logic [TOTAL_W-1:0] HAND,
  output logic [CNT_W-1:0]   CARDS,
  output logic               SOFT,
  output logic               HOLD,
  output logic               BUST,
  output logic               NATURAL
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BEGIN  = 3'd1,
    S_HIT    = 3'd2,
    S_GOT    = 3'd3,
    S_TEST   = 3'd4,
    S_SOFTEN = 3'd5,
    S_HOLD   = 3'd6,
    S_BUST   = 3'd7
  } state_t;

  localparam logic [TOTAL_W-1:0] TARGET_T   = TOTAL_W'(TARGET);
  localparam logic [TOTAL_W-1:0] STAND_T    = TOTAL_W'(STAND_AT);
  localparam logic [TOTAL_W-1:0] DROP_T     = TOTAL_W'(ACE_DROP);
  localparam logic [CARD_W-1:0]  ACE_C      = CARD_W'(ACE_VAL);
  localparam logic [CNT_W-1:0]   MAX_C      = CNT_W'(MAX_CARDS);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_SAT    = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [CNT_W-1:0]   aces_q,  aces_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // State and hand registers; reset clears immediately, independent of the clock.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      total_q <= '0;
      aces_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      aces_q  <= aces_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update; a new-game request beats everything else.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    aces_d  = aces_q;
    count_d = count_q;
    if (NEW_G) begin
      state_d = S_BEGIN;
      total_d = '0;
      aces_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_BEGIN: state_d = S_HIT;
        S_HIT: begin
          if (NEW_C) begin
            total_d = total_q + TOTAL_W'(CARD);
            if (CARD == ACE_C && aces_q != CNT_SAT) aces_d = aces_q + CNT_ONE;
            count_d = count_q + CNT_ONE;
            state_d = S_GOT;
          end
        end
        // Wait for the strobe to drop so a long strobe is not counted twice.
        S_GOT: if (!NEW_C) state_d = S_TEST;
        S_TEST: begin
          if (total_q > TARGET_T)      state_d = (aces_q != '0) ? S_SOFTEN : S_BUST;
          else if (count_q == MAX_C)   state_d = S_HOLD;
          else if (total_q >= STAND_T) state_d = S_HOLD;
          else                         state_d = S_HIT;
        end
        S_SOFTEN: begin
          total_d = total_q - DROP_T;
          aces_d  = aces_q - CNT_ONE;
          state_d = S_TEST;
        end
        S_HOLD:  state_d = S_HOLD;
        S_BUST:  state_d = S_BUST;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from registers only.
  always_comb begin
    NEXT_C  = (state_q == S_HIT);
    HOLD    = (state_q == S_HOLD);
    BUST    = (state_q == S_BUST);
    HAND    = total_q;
    CARDS   = count_q;
    SOFT    = (aces_q != '0);
    NATURAL = (state_q == S_HOLD) && (count_q == CNT_W'(2)) && (total_q == TARGET_T);
  end

endmodule

// File: tb/tb_bjack_hand_ctrl.sv
module tb_bjack_hand_ctrl;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] CARD  = '0;
  logic       NEW_C = 1'b0;
  logic       NEW_G = 1'b0;
  logic       NEXT_C;
  logic [5:0] HAND;
  logic [2:0] CARDS;
  logic       SOFT, HOLD, BUST, NATURAL;

  int checks = 0;
  int errors = 0;

  bjack_hand_ctrl dut (
    .CLOCK(CLOCK), .RESET(RESET), .CARD(CARD), .NEW_C(NEW_C), .NEW_G(NEW_G),
    .NEXT_C(NEXT_C), .HAND(HAND), .CARDS(CARDS), .SOFT(SOFT),
    .HOLD(HOLD), .BUST(BUST), .NATURAL(NATURAL)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic new_game();
    @(negedge CLOCK);
    NEW_G = 1'b1;
    step();
    NEW_G = 1'b0;
    chk("ng_begin_nextc", NEXT_C, 0);
    chk("ng_clear_hand", HAND, 0);
    step();
    chk("ng_hit_nextc", NEXT_C, 1);
  endtask

  // Present one card, keeping the strobe high for 'hold' edges in total.
  task automatic deal(input int v, input int hold);
    int i;
    for (i = 0; i < 20 && !NEXT_C; i++) step();
    if (!NEXT_C) chk("deal_wait_nextc", NEXT_C, 1);
    @(negedge CLOCK);
    CARD  = 4'(v);
    NEW_C = 1'b1;
    step();
    chk("accept_nextc_drop", NEXT_C, 0);
    for (int k = 1; k < hold; k++) step();
    NEW_C = 1'b0;
  endtask

  task automatic settle();
    int i;
    for (i = 0; i < 20 && !(NEXT_C || HOLD || BUST); i++) step();
    if (!(NEXT_C || HOLD || BUST)) chk("settle_timeout", 0, 1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_hand", HAND, 0);
    chk("rst_nextc", NEXT_C, 0);
    chk("rst_flags", {SOFT, HOLD, BUST, NATURAL}, 0);
    step();
    step();
    RESET = 1'b0;
    step();
    step();
    chk("idle_stays", NEXT_C, 0);

    // 10, 7 -> hold at 17, with exact verdict latency
    new_game();
    deal(10, 1);
    chk("c10_hand", HAND, 10);
    settle();
    deal(7, 1);
    chk("c7_hand_on_accept", HAND, 17);
    step();
    chk("c7_test_not_yet", HOLD, 0);
    step();
    chk("c7_hold", HOLD, 1);
    chk("c7_cards", CARDS, 2);
    chk("c7_natural", NATURAL, 0);
    chk("c7_nextc", NEXT_C, 0);

    // 11, 10 -> natural
    new_game();
    deal(11, 1); settle();
    chk("ace_soft", SOFT, 1);
    deal(10, 1); settle();
    chk("nat_hand", HAND, 21);
    chk("nat_hold", HOLD, 1);
    chk("nat_flag", NATURAL, 1);
    chk("nat_soft", SOFT, 1);

    // Multiple aces: 11, 11, 10, 10
    new_game();
    deal(11, 1); settle();
    deal(11, 1); settle();
    chk("aa_hand", HAND, 12);
    chk("aa_soft", SOFT, 1);
    chk("aa_hit", NEXT_C, 1);
    deal(10, 1); settle();
    chk("aa10_hand", HAND, 12);
    chk("aa10_soft", SOFT, 0);
    chk("aa10_hit", NEXT_C, 1);
    deal(10, 1); settle();
    chk("aa1010_hand", HAND, 22);
    chk("aa1010_bust", BUST, 1);
    chk("aa1010_cards", CARDS, 4);

    // 10, 6, 10 -> bust, sticky against strobes
    new_game();
    deal(10, 1); settle();
    deal(6, 1); settle();
    chk("c16_hit", NEXT_C, 1);
    deal(10, 1); settle();
    chk("b26_hand", HAND, 26);
    chk("b26_bust", BUST, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK);
      NEW_C = i[0];
      CARD  = 4'd5;
      step();
    end
    NEW_C = 1'b0;
    chk("bust_sticky", BUST, 1);
    chk("bust_hand_kept", HAND, 26);
    new_game();

    // Charlie: five 2s, first one with a long strobe
    deal(2, 4);
    chk("long_strobe_hand", HAND, 2);
    chk("long_strobe_cards", CARDS, 1);
    settle();
    chk("long_strobe_hand2", HAND, 2);
    deal(2, 1); settle();
    deal(2, 1); settle();
    deal(2, 1); settle();
    deal(2, 1); settle();
    chk("charlie_hand", HAND, 10);
    chk("charlie_cards", CARDS, 5);
    chk("charlie_hold", HOLD, 1);
    chk("charlie_natural", NATURAL, 0);

    // Async reset while in GOT
    new_game();
    @(negedge CLOCK);
    CARD  = 4'd5;
    NEW_C = 1'b1;
    step();
    chk("got_hand", HAND, 5);
    #2 RESET = 1'b1;
    #1;
    chk("async_hand", HAND, 0);
    chk("async_cards", CARDS, 0);
    chk("async_flags", {NEXT_C, SOFT, HOLD, BUST, NATURAL}, 0);
    RESET = 1'b0;
    step();
    chk("post_rst_idle", NEXT_C, 0);

    // NEW_G beats NEW_C
    @(negedge CLOCK);
    NEW_G = 1'b1;
    CARD  = 4'd9;
    step();
    NEW_G = 1'b0;
    NEW_C = 1'b0;
    chk("ng_over_nc_hand", HAND, 0);
    chk("ng_over_nc_cards", CARDS, 0);
    chk("ng_over_nc_nextc", NEXT_C, 0);
    step();
    chk("ng_over_nc_hit", NEXT_C, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
